fp_add_issue_unit: RTL

- Upstream front end of the floating-point adder datapath and controller.
- Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake, unpacks them into sign/exponent/mantissa fields and resolves special cases (zero, Inf, NaN) without invoking the adder.
- For all other pairs it drives the adder's start/done handshake, then repacks the adder result and presents it on a valid/ready output.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_classify.sv | 28 ++
 rtl/fp_add_issue_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, FSM states and operand type for the FP adder front end
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_OUT
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   man;
    } operand_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - unpacks one single-precision operand and flags zero/Inf/NaN
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       i_op,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W:0]   o_man
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    assign w_exp  = i_op[FRAC_W +: EXP_W];
    assign w_frac = i_op[FRAC_W-1:0];

    // Denormals are flushed: a zero exponent means zero regardless of fraction.
    assign o_is_zero = (w_exp == '0);
    assign o_is_inf  = (w_exp == EXP_MAX) && (w_frac == '0);
    assign o_is_nan  = (w_exp == EXP_MAX) && (w_frac != '0);
    assign o_sign    = i_op[31];
    assign o_exp     = w_exp;
    assign o_man     = o_is_zero ? '0 : {1'b1, w_frac};

endmodule

// File: rtl/fp_add_issue_unit.sv
// rtl/fp_add_issue_unit.sv - operand intake, special-case bypass and adder handshake sequencing
module fp_add_issue_unit #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic              start,
    input  logic              done,
    output logic              a_sign,
    output logic              b_sign,
    output logic [EXP_W-1:0]  a_exp,
    output logic [EXP_W-1:0]  b_exp,
    output logic [FRAC_W:0]   a_man,
    output logic [FRAC_W:0]   b_man,
    input  logic              r_sign,
    input  logic [EXP_W-1:0]  r_exp,
    input  logic [FRAC_W:0]   r_man,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data
);

    fp_pkg::state_e   r_state;
    fp_pkg::operand_t w_op_a;
    fp_pkg::operand_t w_op_b;

    logic              w_a_zero, w_a_inf, w_a_nan, w_a_sign;
    logic              w_b_zero, w_b_inf, w_b_nan, w_b_sign;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp;
    logic [FRAC_W:0]   w_a_man, w_b_man;
    logic              w_special;
    logic [31:0]       w_bypass;
    logic [31:0]       w_packed;

    fp_classify u_cls_a (
        .i_op      (in_a),
        .o_is_zero (w_a_zero),
        .o_is_inf  (w_a_inf),
        .o_is_nan  (w_a_nan),
        .o_sign    (w_a_sign),
        .o_exp     (w_a_exp),
        .o_man     (w_a_man)
    );

    fp_classify u_cls_b (
        .i_op      (in_b),
        .o_is_zero (w_b_zero),
        .o_is_inf  (w_b_inf),
        .o_is_nan  (w_b_nan),
        .o_sign    (w_b_sign),
        .o_exp     (w_b_exp),
        .o_man     (w_b_man)
    );

    assign w_op_a = '{sign: w_a_sign, exp: w_a_exp, man: w_a_man};
    assign w_op_b = '{sign: w_b_sign, exp: w_b_exp, man: w_b_man};

    // Pairs the adder never needs to see, in priority order.
    always_comb begin
        w_special = 1'b1;
        w_bypass  = '0;
        if (w_a_nan || w_b_nan)
            w_bypass = fp_pkg::QNAN;
        else if (w_a_inf && w_b_inf && (w_a_sign != w_b_sign))
            w_bypass = fp_pkg::QNAN;
        else if (w_a_inf)
            w_bypass = in_a;
        else if (w_b_inf)
            w_bypass = in_b;
        else if (w_a_zero && w_b_zero)
            w_bypass = {w_a_sign & w_b_sign, {(EXP_W+FRAC_W){1'b0}}};
        else if (w_a_zero)
            w_bypass = in_b;
        else if (w_b_zero)
            w_bypass = in_a;
        else
            w_special = 1'b0;
    end

    always_comb begin
        w_packed = '0;
        if (r_man == '0)
            w_packed = '0;
        else if (r_exp == {EXP_W{1'b1}})
            w_packed = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else
            w_packed = {r_sign, r_exp, r_man[FRAC_W-1:0]};
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_state   <= fp_pkg::ST_IDLE;
            in_ready  <= 1'b1;
            start     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            a_exp     <= '0;
            b_exp     <= '0;
            a_man     <= '0;
            b_man     <= '0;
        end else begin
            case (r_state)
                fp_pkg::ST_IDLE: begin
                    if (in_valid) begin
                        a_sign   <= w_op_a.sign;
                        a_exp    <= w_op_a.exp;
                        a_man    <= w_op_a.man;
                        b_sign   <= w_op_b.sign;
                        b_exp    <= w_op_b.exp;
                        b_man    <= w_op_b.man;
                        in_ready <= 1'b0;
                        if (w_special) begin
                            res_data  <= w_bypass;
                            res_valid <= 1'b1;
                            r_state   <= fp_pkg::ST_OUT;
                        end else begin
                            start   <= 1'b1;
                            r_state <= fp_pkg::ST_ISSUE;
                        end
                    end
                end
                fp_pkg::ST_ISSUE: begin
                    start   <= 1'b0;
                    r_state <= fp_pkg::ST_WAIT_BUSY;
                end
                // A done still high from the previous operation must not count as completion.
                fp_pkg::ST_WAIT_BUSY: begin
                    if (!done)
                        r_state <= fp_pkg::ST_WAIT_DONE;
                end
                fp_pkg::ST_WAIT_DONE: begin
                    if (done) begin
                        res_data  <= w_packed;
                        res_valid <= 1'b1;
                        r_state   <= fp_pkg::ST_OUT;
                    end
                end
                fp_pkg::ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= fp_pkg::ST_IDLE;
                    end
                end
                default: begin
                    start     <= 1'b0;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= fp_pkg::ST_IDLE;
                end
            endcase
        end
    end

endmodule
